// File: rtl/tl_code_channel_driver.sv
`default_nettype none
// tl_code_channel_driver: LFSR-driven A-channel request generator with in-order D-channel checking.
// Rev 1.0 - initial release.
module tl_code_channel_driver #(
  parameter int unsigned NUM_TXN         = 16,
  parameter logic [15:0] SEED            = 16'hACE1,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       start,
  input  logic       inject_err,
  input  logic       err_sel,
  output logic       a_valid,
  input  logic       a_ready,
  output logic [3:0] a_code,
  output logic [1:0] a_id,
  input  logic       d_valid,
  output logic       d_ready,
  input  logic [3:0] d_code,
  input  logic [1:0] d_id,
  output logic       busy,
  output logic       done,
  output logic [7:0] sent_count,
  output logic [7:0] recv_count,
  output logic       proto_err
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_e;

  localparam logic [2:0] MAX_OUT  = 3'(MAX_OUTSTANDING);
  localparam logic [7:0] LAST_IDX = 8'(NUM_TXN - 1);

  state_e      state_q, state_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic [7:0]  sent_q, sent_d, recv_q, recv_d;
  logic [2:0]  outst_q, outst_d;
  logic [1:0]  next_id_q, next_id_d, oldest_id_q, oldest_id_d;
  logic        perr_q, perr_d, inj_q, inj_d, sel_q, sel_d;
  logic        launch, a_fire, d_fire, d_pop;
  logic [3:0]  mapped;

  assign launch     = start && (state_q == S_IDLE || state_q == S_DONE);
  assign busy       = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done       = (state_q == S_DONE);
  assign d_ready    = busy;
  assign a_valid    = (state_q == S_RUN) && (outst_q < MAX_OUT);
  assign a_fire     = a_valid && a_ready;
  assign d_fire     = d_valid && d_ready;
  assign d_pop      = d_fire && (outst_q != 3'd0);
  assign a_id       = next_id_q;
  assign sent_count = sent_q;
  assign recv_count = recv_q;
  assign proto_err  = perr_q;

  // Reserved codes 0 and 8 are remapped so legal traffic never carries them.
  always_comb begin
    mapped = lfsr_q[3:0];
    if (lfsr_q[3:0] == 4'h0)      mapped = 4'h1;
    else if (lfsr_q[3:0] == 4'h8) mapped = 4'h9;
  end

  // The code only changes on acceptance, so a pending beat stays stable.
  assign a_code = !a_valid                      ? 4'h0 :
                  (inj_q && sent_q == 8'd3)     ? {sel_q, 3'b000} : mapped;

  always_comb begin
    state_d     = state_q;
    lfsr_d      = lfsr_q;
    sent_d      = sent_q;
    recv_d      = recv_q;
    outst_d     = outst_q;
    next_id_d   = next_id_q;
    oldest_id_d = oldest_id_q;
    perr_d      = perr_q;
    inj_d       = inj_q;
    sel_d       = sel_q;

    case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (a_fire && sent_q == LAST_IDX) state_d = S_DRAIN;
      S_DRAIN: if (outst_q == 3'd0) state_d = S_DONE;
      S_DONE:  if (start) state_d = S_RUN;
      default: state_d = S_IDLE;
    endcase

    if (launch) begin
      lfsr_d      = SEED;
      sent_d      = 8'd0;
      recv_d      = 8'd0;
      outst_d     = 3'd0;
      next_id_d   = 2'd0;
      oldest_id_d = 2'd0;
      perr_d      = 1'b0;
      inj_d       = inject_err;
      sel_d       = err_sel;
    end else begin
      if (a_fire) begin
        lfsr_d    = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        next_id_d = next_id_q + 2'd1;
        if (sent_q != 8'hFF) sent_d = sent_q + 8'd1;
      end
      if (d_fire) begin
        if (recv_q != 8'hFF) recv_d = recv_q + 8'd1;
        if (outst_q == 3'd0 || d_id != oldest_id_q || d_code == 4'h0 || d_code == 4'h8)
          perr_d = 1'b1;
      end
      if (d_pop) oldest_id_d = oldest_id_q + 2'd1;
      outst_d = outst_q + {2'b00, a_fire} - {2'b00, d_pop};
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      lfsr_q      <= SEED;
      sent_q      <= 8'd0;
      recv_q      <= 8'd0;
      outst_q     <= 3'd0;
      next_id_q   <= 2'd0;
      oldest_id_q <= 2'd0;
      perr_q      <= 1'b0;
      inj_q       <= 1'b0;
      sel_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      lfsr_q      <= lfsr_d;
      sent_q      <= sent_d;
      recv_q      <= recv_d;
      outst_q     <= outst_d;
      next_id_q   <= next_id_d;
      oldest_id_q <= oldest_id_d;
      perr_q      <= perr_d;
      inj_q       <= inj_d;
      sel_q       <= sel_d;
    end
  end

endmodule
`default_nettype wire
